vec_lsu: RTL and testbench

Vector load/store sequencer for the RV32IMV datapath. Accepts one unit-stride or strided vector memory command, issues one element access per cycle to the word-addressed data memory (combinational read, clocked write, 4-bit write-enable), and assembles loaded elements into a vector-register write. It sits between the vector register file / decode and the data memory, driving the memory's address, write-enable and write-data, and consuming its read data.

---
 rtl/vlsu_pkg.sv | 26 ++
 rtl/vec_lsu_if.sv | 55 +++++
 rtl/vlsu_elem_fmt.sv | 34 +++
 rtl/vec_lsu.sv | 135 +++++++++++++
 tb/tb_vec_lsu.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vlsu_pkg.sv
// -----------------------------------------------------------------------------
// vlsu_pkg
// Shared types and constants for the vector load/store sequencer:
//   state_t          sequencer states IDLE / RUN / DONE
//   SEW_8/16/32      element-width encodings (2'b11 is handled as 32-bit)
//   WE_*             data-memory byte write-enable patterns
// Optional feature macro used by the block: VLSU_MASK_EN (per-element mask).
// -----------------------------------------------------------------------------
package vlsu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [1:0] SEW_8  = 2'b00;
   localparam logic [1:0] SEW_16 = 2'b01;
   localparam logic [1:0] SEW_32 = 2'b10;

   localparam logic [3:0] WE_WORD = 4'b1111;
   localparam logic [3:0] WE_HALF = 4'b0011;
   localparam logic [3:0] WE_BYTE = 4'b0001;
   localparam logic [3:0] WE_NONE = 4'b0000;

endpackage

// File: rtl/vec_lsu_if.sv
// -----------------------------------------------------------------------------
// vec_lsu_if
// Bundles the command side (decode / vector register file) and the data-memory
// side of vec_lsu.
//   command in : start, is_store, base, stride, vl, sew, vs_data (vmask)
//   status out : busy, done, vd_we, vd_data
//   memory     : mem_addr, mem_we, mem_din out; mem_dout in (combinational read)
// modport slave  : the sequencer itself
// modport master : whoever drives commands and models the memory
// Macro VLSU_MASK_EN adds the vmask command input.
// -----------------------------------------------------------------------------
interface vec_lsu_if #(
   parameter int NELEM = 4,
   parameter int VLW   = 3
);
   logic                   start;
   logic                   is_store;
   logic [31:0]            base;
   logic [31:0]            stride;
   logic [VLW-1:0]         vl;
   logic [1:0]             sew;
   logic [NELEM-1:0][31:0] vs_data;
`ifdef VLSU_MASK_EN
   logic [NELEM-1:0]       vmask;
`endif
   logic                   busy;
   logic                   done;
   logic                   vd_we;
   logic [NELEM-1:0][31:0] vd_data;
   logic [31:0]            mem_addr;
   logic [3:0]             mem_we;
   logic [31:0]            mem_din;
   logic [31:0]            mem_dout;

`ifdef VLSU_MASK_EN
   modport slave (
      input  start, is_store, base, stride, vl, sew, vs_data, vmask, mem_dout,
      output busy, done, vd_we, vd_data, mem_addr, mem_we, mem_din
   );
   modport master (
      output start, is_store, base, stride, vl, sew, vs_data, vmask, mem_dout,
      input  busy, done, vd_we, vd_data, mem_addr, mem_we, mem_din
   );
`else
   modport slave (
      input  start, is_store, base, stride, vl, sew, vs_data, mem_dout,
      output busy, done, vd_we, vd_data, mem_addr, mem_we, mem_din
   );
   modport master (
      output start, is_store, base, stride, vl, sew, vs_data, mem_dout,
      input  busy, done, vd_we, vd_data, mem_addr, mem_we, mem_din
   );
`endif

endinterface

// File: rtl/vlsu_elem_fmt.sv
// -----------------------------------------------------------------------------
// vlsu_elem_fmt
// Combinational element formatting by element width.
//   i_sew   : element width encoding (2'b11 behaves as 32-bit)
//   i_rdata : raw memory read word
//   o_we    : byte write-enable pattern for a store of this width
//   o_sext  : low element bits of i_rdata sign-extended to 32
// -----------------------------------------------------------------------------
module vlsu_elem_fmt
   import vlsu_pkg::*;
(
   input  logic [1:0]  i_sew,
   input  logic [31:0] i_rdata,
   output logic [3:0]  o_we,
   output logic [31:0] o_sext
);

   always_comb begin
      o_we   = WE_WORD;
      o_sext = i_rdata;
      case (i_sew)
         SEW_8: begin
            o_we   = WE_BYTE;
            o_sext = {{24{i_rdata[7]}}, i_rdata[7:0]};
         end
         SEW_16: begin
            o_we   = WE_HALF;
            o_sext = {{16{i_rdata[15]}}, i_rdata[15:0]};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/vec_lsu.sv
// -----------------------------------------------------------------------------
// vec_lsu
// Vector load/store sequencer. Accepts one unit-stride or strided vector memory
// command, issues one element access per cycle to a word-addressed data memory
// and assembles loaded elements into a vector-register write.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : vec_lsu_if.slave (command, status, data-memory signals)
// Memory-side outputs are registered: the element presented in a cycle is set
// up on the preceding edge. Loads capture mem_dout at the end of that cycle.
// Macro VLSU_MASK_EN: per-element mask latched at start; masked-off elements
// keep their cycle and address step but write nothing and keep their old lane.
// -----------------------------------------------------------------------------
module vec_lsu
   import vlsu_pkg::*;
#(
   parameter int NELEM = 4,
   parameter int VLW   = 3
) (
   input  logic    clk,
   input  logic    rst,
   vec_lsu_if.slave bus
);

   state_t                 r_state, w_next;
   logic                   r_is_store;
   logic [31:0]            r_stride;
   logic [VLW-1:0]         r_vl, r_idx, w_vl;
   logic [1:0]             r_sew, w_sew;
   // Remaining store data / mask, shifted so index 0 is the current element.
   logic [NELEM-1:0][31:0] r_vs;
   logic [NELEM-1:0]       r_act, w_mask;
   logic [NELEM-1:0][31:0] r_vd;
   logic [31:0]            r_mem_addr, r_mem_din;
   logic [3:0]             r_mem_we;
   logic                   w_accept, w_last;
   logic [3:0]             w_we;
   logic [31:0]            w_sext;

`ifdef VLSU_MASK_EN
   assign w_mask = bus.vmask;
`else
   assign w_mask = '1;
`endif

   assign w_vl     = (bus.vl > VLW'(NELEM)) ? VLW'(NELEM) : bus.vl;
   assign w_accept = (r_state == IDLE) && bus.start;
   assign w_last   = (r_idx == r_vl - VLW'(1));
   // Width for the element being set up: the incoming one on accept.
   assign w_sew    = w_accept ? bus.sew : r_sew;

   vlsu_elem_fmt u_fmt (
      .i_sew   (w_sew),
      .i_rdata (bus.mem_dout),
      .o_we    (w_we),
      .o_sext  (w_sext)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (bus.start) w_next = (w_vl == '0) ? DONE : RUN;
         RUN:     if (w_last) w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_is_store <= 1'b0;
         r_stride   <= '0;
         r_vl       <= '0;
         r_sew      <= SEW_8;
         r_idx      <= '0;
         r_vs       <= '0;
         r_act      <= '0;
         r_vd       <= '0;
         r_mem_addr <= '0;
         r_mem_we   <= WE_NONE;
         r_mem_din  <= '0;
      end else begin
         case (r_state)
            IDLE: if (bus.start) begin
               r_is_store <= bus.is_store;
               r_stride   <= bus.stride;
               r_vl       <= w_vl;
               r_sew      <= bus.sew;
               r_idx      <= '0;
               r_vs       <= bus.vs_data;
               r_act      <= w_mask;
               // Active and tail lanes clear; masked-off lanes below vl hold.
               for (int i = 0; i < NELEM; i++)
                  if (!((VLW'(i) < w_vl) && !w_mask[i])) r_vd[i] <= '0;
               if (w_vl != '0) begin
                  r_mem_addr <= bus.base;
                  r_mem_we   <= (bus.is_store && w_mask[0]) ? w_we : WE_NONE;
                  r_mem_din  <= bus.is_store ? bus.vs_data[0] : '0;
               end
            end
            RUN: begin
               if (!r_is_store && r_act[0])
                  for (int i = 0; i < NELEM; i++)
                     if (VLW'(i) == r_idx) r_vd[i] <= w_sext;
               if (w_last) begin
                  r_mem_addr <= '0;
                  r_mem_we   <= WE_NONE;
                  r_mem_din  <= '0;
               end else begin
                  r_idx      <= r_idx + VLW'(1);
                  r_mem_addr <= r_mem_addr + r_stride;
                  r_mem_we   <= (r_is_store && r_act[1]) ? w_we : WE_NONE;
                  r_mem_din  <= r_is_store ? r_vs[1] : '0;
                  r_vs       <= r_vs >> 32;
                  r_act      <= r_act >> 1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy     = (r_state == RUN);
   assign bus.done     = (r_state == DONE);
   assign bus.vd_we    = (r_state == DONE) && !r_is_store;
   assign bus.vd_data  = r_vd;
   assign bus.mem_addr = r_mem_addr;
   assign bus.mem_we   = r_mem_we;
   assign bus.mem_din  = r_mem_din;

endmodule

// File: tb/tb_vec_lsu.sv
// -----------------------------------------------------------------------------
// tb_vec_lsu
// Self-checking bench for vec_lsu. A command model turns each accepted command
// into the per-cycle memory-side/status outputs it must produce; a single
// compare process checks every cycle against that schedule (idle values when
// nothing is scheduled). Directed tests add hand-computed literal checks on
// the loaded lanes, completion latency and final memory contents.
// -----------------------------------------------------------------------------
module tb_vec_lsu;
   import vlsu_pkg::*;

   localparam int NELEM = 4;
   localparam int VLW   = 3;

   typedef struct packed {
      logic [31:0]       addr;
      logic [3:0]        we;
      logic [31:0]       din;
      logic              busy;
      logic              done;
      logic              vdwe;
      logic              chkvd;
      logic [3:0][31:0]  vd;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   vec_lsu_if #(.NELEM(NELEM), .VLW(VLW)) bus();
   vec_lsu #(.NELEM(NELEM), .VLW(VLW)) dut (.clk(clk), .rst(rst), .bus(bus));

   int errors = 0;
   int checks = 0;
   exp_t q[$];

   // Data memory: 64 words, combinational read, byte-enabled clocked write.
   logic [31:0] mem [64];
   logic        clr = 1'b0, ld_en = 1'b0;
   logic [5:0]  ld_idx = '0;
   logic [31:0] ld_val = '0;
   assign bus.mem_dout = mem[bus.mem_addr[7:2]];
   always @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < 64; i++) mem[i] <= '0;
      end else if (ld_en) begin
         mem[ld_idx] <= ld_val;
      end else begin
         for (int b = 0; b < 4; b++)
            if (bus.mem_we[b]) mem[bus.mem_addr[7:2]][8*b +: 8] <= bus.mem_din[8*b +: 8];
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h @%0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] we_of(input logic [1:0] s);
      return (s == 2'b00) ? 4'b0001 : (s == 2'b01) ? 4'b0011 : 4'b1111;
   endfunction

   function automatic logic [31:0] sx(input logic [31:0] w, input logic [1:0] s);
      if (s == 2'b00) return {{24{w[7]}}, w[7:0]};
      if (s == 2'b01) return {{16{w[15]}}, w[15:0]};
      return w;
   endfunction

   // Schedule of outputs for one accepted command, one entry per cycle.
   task automatic model_push(input bit st, input logic [31:0] base, input logic [31:0] stride,
                             input logic [2:0] vl, input logic [1:0] sew,
                             input logic [3:0][31:0] vs);
      int   n;
      exp_t e;
      logic [31:0] a;
      n = (vl > 3'd4) ? 4 : int'(vl);
      for (int k = 0; k < n; k++) begin
         e = '0;
         e.addr = base + stride * k;
         e.we   = st ? we_of(sew) : 4'b0000;
         e.din  = st ? vs[k] : 32'h0;
         e.busy = 1'b1;
         q.push_back(e);
      end
      e = '0;
      e.done  = 1'b1;
      e.vdwe  = !st;
      e.chkvd = !st;
      for (int i = 0; i < 4; i++) begin
         a = base + stride * i;
         e.vd[i] = (i < n) ? sx(mem[a[7:2]], sew) : 32'h0;
      end
      q.push_back(e);
   endtask

   // Compare process: every cycle, 1 time unit after the rising edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         e = (q.size() > 0) ? q.pop_front() : exp_t'(0);
         chk("mem_addr", bus.mem_addr, e.addr);
         chk("mem_we", 32'(bus.mem_we), 32'(e.we));
         chk("mem_din", bus.mem_din, e.din);
         chk("busy", 32'(bus.busy), 32'(e.busy));
         chk("done", 32'(bus.done), 32'(e.done));
         chk("vd_we", 32'(bus.vd_we), 32'(e.vdwe));
         if (e.chkvd)
            for (int i = 0; i < 4; i++) chk($sformatf("vd_data[%0d]", i), bus.vd_data[i], e.vd[i]);
      end
   end

   // Issue one command; optionally keep start asserted (with junk fields)
   // through RUN and DONE, which must be ignored. Returns cycles to done.
   task automatic run(input bit st, input logic [31:0] base, input logic [31:0] stride,
                      input logic [2:0] vl, input logic [1:0] sew, input logic [3:0][31:0] vs,
                      input bit hold, output int lat);
      int n;
      n = (vl > 3'd4) ? 4 : int'(vl);
      @(negedge clk);
      bus.is_store = st; bus.base = base; bus.stride = stride;
      bus.vl = vl; bus.sew = sew; bus.vs_data = vs; bus.start = 1'b1;
      model_push(st, base, stride, vl, sew, vs);
      lat = -1;
      for (int k = 1; k <= n + 2; k++) begin
         @(negedge clk);
         if (bus.done && lat < 0) lat = k;
         if (hold && k <= n + 1) begin
            bus.start = 1'b1; bus.is_store = !st; bus.base = 32'h0000_00B0;
            bus.vl = 3'd1; bus.vs_data = {4{32'h5A5A_5A5A}};
         end else begin
            bus.start = 1'b0;
         end
      end
      bus.start = 1'b0;
   endtask

   task automatic poke(input int idx, input logic [31:0] v);
      @(negedge clk);
      ld_en = 1'b1; ld_idx = 6'(idx); ld_val = v;
      @(negedge clk);
      ld_en = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      bus.start = 1'b0; bus.is_store = 1'b0; bus.base = '0; bus.stride = '0;
      bus.vl = '0; bus.sew = '0; bus.vs_data = '0;
`ifdef VLSU_MASK_EN
      bus.vmask = '1;
`endif
      // Memory setup while held in reset.
      @(negedge clk); clr = 1'b1;
      @(negedge clk); clr = 1'b0;
      poke(4, 32'd3); poke(5, 32'd5); poke(6, 32'hFFFF_FFF9); poke(7, 32'hFFFF_FFFB);
      poke(8, 32'h0000_00F6); poke(10, 32'h0000_0008);
      poke(1, 32'hA); poke(0, 32'hB); poke(63, 32'hC);
      // Reset state.
      chk("rst busy", 32'(bus.busy), 0);
      chk("rst done", 32'(bus.done), 0);
      chk("rst vd_we", 32'(bus.vd_we), 0);
      chk("rst mem_we", 32'(bus.mem_we), 0);
      chk("rst mem_addr", bus.mem_addr, 0);
      chk("rst mem_din", bus.mem_din, 0);
      chk("rst vd_data", 32'(bus.vd_data != '0), 0);
      @(negedge clk); rst = 1'b0;

      // Unit-stride word load.
      run(1'b0, 32'h10, 32'd4, 3'd4, 2'b10, '0, 1'b0, lat);
      chk("wload latency", 32'(lat), 32'd5);
      chk("wload lane0", bus.vd_data[0], 32'd3);
      chk("wload lane1", bus.vd_data[1], 32'd5);
      chk("wload lane2", bus.vd_data[2], 32'hFFFF_FFF9);
      chk("wload lane3", bus.vd_data[3], 32'hFFFF_FFFB);

      // Strided byte load, tail lanes cleared.
      run(1'b0, 32'h20, 32'd8, 3'd2, 2'b00, '0, 1'b0, lat);
      chk("bload lane0", bus.vd_data[0], 32'hFFFF_FFF6);
      chk("bload lane1", bus.vd_data[1], 32'h0000_0008);
      chk("bload lane2", bus.vd_data[2], 32'h0);
      chk("bload lane3", bus.vd_data[3], 32'h0);

      // Half store.
      run(1'b1, 32'h40, 32'd4, 3'd2, 2'b01, {32'h0, 32'h0, 32'hFFFF_8000, 32'h0000_1234}, 1'b0, lat);
      chk("hstore word0x40", mem[16], 32'h0000_1234);
      chk("hstore word0x44", mem[17], 32'h0000_8000);

      // vl = 0: load writes zero vector, store writes nothing.
      run(1'b0, 32'h10, 32'd4, 3'd0, 2'b10, '0, 1'b0, lat);
      chk("vl0 load latency", 32'(lat), 32'd1);
      run(1'b1, 32'h48, 32'd4, 3'd0, 2'b10, {4{32'hFFFF_FFFF}}, 1'b0, lat);
      chk("vl0 store latency", 32'(lat), 32'd1);
      chk("vl0 store no write", mem[18], 32'h0);

      // vl = 7 clamps to 4; sew 11 behaves as word.
      run(1'b1, 32'h60, 32'd4, 3'd7, 2'b11, {32'd44, 32'd33, 32'd22, 32'd11}, 1'b0, lat);
      chk("clamp latency", 32'(lat), 32'd5);
      chk("clamp word0x60", mem[24], 32'd11);
      chk("clamp word0x6C", mem[27], 32'd44);
      chk("clamp word0x70", mem[28], 32'h0);

      // Negative stride wrap, with start held high through RUN and DONE.
      run(1'b0, 32'h4, 32'hFFFF_FFFC, 3'd3, 2'b10, '0, 1'b1, lat);
      chk("wrap lane0", bus.vd_data[0], 32'hA);
      chk("wrap lane1", bus.vd_data[1], 32'hB);
      chk("wrap lane2", bus.vd_data[2], 32'hC);
      chk("wrap lane3", bus.vd_data[3], 32'h0);
      chk("ignored start no write", mem[44], 32'h0);

      // Reset in the second RUN cycle of a 4-element word store.
      @(negedge clk);
      bus.is_store = 1'b1; bus.base = 32'h80; bus.stride = 32'd4; bus.vl = 3'd4;
      bus.sew = 2'b10; bus.vs_data = {32'd4, 32'd3, 32'd2, 32'd1}; bus.start = 1'b1;
      model_push(1'b1, 32'h80, 32'd4, 3'd4, 2'b10, {32'd4, 32'd3, 32'd2, 32'd1});
      @(negedge clk); bus.start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      q.delete();
      #1;
      chk("abort mem_we", 32'(bus.mem_we), 0);
      chk("abort busy", 32'(bus.busy), 0);
      chk("abort mem_addr", bus.mem_addr, 0);
      @(negedge clk); rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort elem0 written", mem[32], 32'd1);
      chk("abort elem1 not written", mem[33], 32'h0);
      chk("abort elem2 not written", mem[34], 32'h0);
      chk("schedule drained", 32'(q.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
